// File: rtl/fir_mac_arbiter.sv
// fir_mac_arbiter: round-robin arbitration of NREQ FIR requesters onto one pipelined
// multiply / dequantize / accumulate unit, with result writeback to the owner's FIFO.
module fir_mac_arbiter #(
    parameter int DATA_SIZE = 32,
    parameter int NREQ      = 2,
    parameter int DEQ_SHIFT = 10
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NREQ-1:0]                req,
    input  logic [NREQ-1:0]                last,
    input  logic [NREQ-1:0][DATA_SIZE-1:0] a_in,
    input  logic [NREQ-1:0][DATA_SIZE-1:0] b_in,
    output logic [NREQ-1:0]                gnt,
    input  logic [NREQ-1:0]                res_full,
    output logic [NREQ-1:0]                res_valid,
    output logic [DATA_SIZE-1:0]           res_dout,
    output logic                           busy
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW = 2 * DATA_SIZE;

    typedef enum logic [1:0] {IDLE, BURST, DRAIN, WRITE} state_t;

    state_t               r_state, w_next;
    logic [OW-1:0]        r_owner, r_rr_ptr, w_pick;
    logic                 r_dcnt, r_pv, w_take, w_wr;
    logic [PW-1:0]        r_prod, w_mag;
    logic [DATA_SIZE-1:0] r_acc, w_sh, w_dq;
    logic signed [PW-1:0] w_a, w_b;
    logic [NREQ-1:0]      w_own;

    assign w_own  = NREQ'(1) << r_owner;
    assign w_take = (r_state == BURST) && req[r_owner];
    assign w_wr   = (r_state == WRITE) && !res_full[r_owner];
    assign w_a    = PW'($signed(a_in[r_owner]));
    assign w_b    = PW'($signed(b_in[r_owner]));
    // Shift the magnitude so negative products truncate toward zero.
    assign w_mag  = r_prod[PW-1] ? -r_prod : r_prod;
    assign w_sh   = DATA_SIZE'(w_mag >> DEQ_SHIFT);
    assign w_dq   = r_prod[PW-1] ? -w_sh : w_sh;

    assign gnt       = (r_state == BURST) ? w_own : '0;
    assign res_valid = w_wr ? w_own : '0;
    assign res_dout  = w_wr ? r_acc : '0;
    assign busy      = (r_state != IDLE);

    // Descending scan so the requester closest above rr_ptr is the last to overwrite.
    always_comb begin
        w_pick = r_rr_ptr;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req[(int'(r_rr_ptr) + k) % NREQ])
                w_pick = OW'((int'(r_rr_ptr) + k) % NREQ);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (|req) ? BURST : IDLE;
            BURST:   w_next = (w_take && last[r_owner]) ? DRAIN : BURST;
            DRAIN:   w_next = r_dcnt ? WRITE : DRAIN;
            WRITE:   w_next = res_full[r_owner] ? WRITE : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_dcnt   <= 1'b0;
            r_pv     <= 1'b0;
            r_prod   <= '0;
            r_acc    <= '0;
        end else begin
            r_pv   <= w_take;
            r_prod <= w_take ? w_a * w_b : r_prod;
            r_dcnt <= (r_state == DRAIN) && !r_dcnt;
            if (r_state == IDLE && |req) begin
                r_owner <= w_pick;
                r_acc   <= '0;
            end else if (r_pv)
                r_acc <= r_acc + w_dq;
            if (w_wr)
                r_rr_ptr <= (r_owner == OW'(NREQ - 1)) ? '0 : r_owner + OW'(1);
        end
    end
endmodule

// File: tb/tb_fir_mac_arbiter.sv
// tb_fir_mac_arbiter: directed bursts; results and grant order checked by queue-fed monitors.
module tb_fir_mac_arbiter;
    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [1:0]        req = '0, last = '0, res_full = '0;
    logic [1:0][31:0]  a_in = '0, b_in = '0;
    logic [1:0]        gnt, res_valid;
    logic [31:0]       res_dout;
    logic              busy;

    typedef struct {int idx; logic [31:0] d;} exp_t;
    exp_t exp_q[$];
    int   gq[$];
    int   passed = 0, total = 0, cyc = 0, v_cyc = 0, g_len = 0;
    logic [1:0] prev_gnt = '0;

    fir_mac_arbiter dut (
        .clock(clock), .reset(reset), .req(req), .last(last), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .res_full(res_full), .res_valid(res_valid), .res_dout(res_dout), .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
    endtask

    task automatic fail(input string n);
        total++;
        $display("FAIL %s: timed out", n);
    endtask

    // Offer one term and return the edge count at which it was accepted.
    task automatic term(input int i, input logic [31:0] a, input logic [31:0] b,
                        input bit l, output int e);
        int n = 0;
        bit g = 0;
        req[i] = 1'b1; a_in[i] = a; b_in[i] = b; last[i] = l;
        do begin
            @(negedge clock) g = gnt[i];
            @(posedge clock) #1;
            n++;
        end while (!g && n < 200);
        if (!g) fail("term_grant_wait");
        e = cyc;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (n >= 300) fail("wait_idle");
        @(posedge clock) #1;
    endtask

    always @(negedge clock) begin
        exp_t x;
        if (res_valid != 0) begin
            v_cyc = cyc;
            if (exp_q.size() == 0) chk("spurious_res_valid", 64'(res_valid), 64'(0));
            else begin
                x = exp_q.pop_front();
                chk("res_valid", 64'(res_valid), 64'(2'b01 << x.idx));
                chk("res_dout", 64'(res_dout), 64'(x.d));
            end
        end
    end

    always @(negedge clock) begin
        int gi;
        if (gnt != 0 && gnt != prev_gnt) begin
            if (gq.size() == 0) chk("spurious_gnt", 64'(gnt), 64'(0));
            else begin
                gi = gq.pop_front();
                chk("gnt_owner", 64'(gnt), 64'(2'b01 << gi));
            end
            g_len = 1;
        end else if (gnt != 0)
            g_len++;
        prev_gnt = gnt;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        repeat (2) @(posedge clock);
        #1 chk("reset_outputs", 64'({gnt, res_valid, res_dout, busy}), 64'(0));
        @(negedge clock) reset = 1'b1;

        // three terms of 1024*5, each dequantizes to 5
        gq.push_back(0);
        term(0, 1024, 5, 0, e);
        term(0, 1024, 5, 0, e);
        term(0, 1024, 5, 1, e);
        exp_q.push_back('{0, 32'd15});
        req[0] = 0; last[0] = 0;
        chk("burst_gnt_len", 64'(g_len), 64'(3));
        wait_idle();
        chk("result_latency", 64'(v_cyc - e), 64'(2));
        chk("rr_ptr_after_0", 64'(dut.r_rr_ptr), 64'(1));

        // truncation toward zero on negative products
        gq.push_back(0);
        term(0, 32'hFFFF_FFFF, 1023, 1, e);
        exp_q.push_back('{0, 32'd0});
        req[0] = 0; last[0] = 0;
        wait_idle();
        gq.push_back(0);
        term(0, -32'sd2048, 1, 1, e);
        exp_q.push_back('{0, 32'hFFFF_FFFE});
        req[0] = 0; last[0] = 0;
        wait_idle();

        // owner 1 writeback stalled by its full FIFO
        res_full = 2'b10;
        gq.push_back(1);
        term(1, 3072, 1, 0, e);
        term(1, 3072, 1, 1, e);
        exp_q.push_back('{1, 32'd6});
        req[1] = 0; last[1] = 0;
        repeat (2) @(negedge clock);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("full_hold", 64'({busy, gnt, res_valid}), 64'(5'b10000));
        end
        @(posedge clock) #1 res_full = 2'b00;
        wait_idle();

        // owner 0 with bubbles while requester 1 waits
        gq.push_back(0);
        gq.push_back(1);
        fork
            begin
                int e0;
                term(0, 2048, 1, 0, e0);
                req[0] = 0; @(posedge clock) #1;
                req[0] = 1; @(posedge clock) #1;
                req[0] = 0; @(posedge clock) #1;
                req[0] = 1; last[0] = 1; @(posedge clock) #1;
                exp_q.push_back('{0, 32'd6});
                req[0] = 0; last[0] = 0;
                chk("bubble_gnt_len", 64'(g_len), 64'(5));
            end
            begin
                int e1;
                term(1, 1024, 1, 1, e1);
                exp_q.push_back('{1, 32'd1});
                req[1] = 0; last[1] = 0;
            end
        join
        wait_idle();

        // reset, then both requesters held high with 2-term bursts
        @(negedge clock) reset = 1'b0;
        @(negedge clock) reset = 1'b1;
        gq.push_back(0); gq.push_back(1); gq.push_back(0); gq.push_back(1);
        fork
            begin
                int e0;
                for (int r = 0; r < 2; r++) begin
                    term(0, 1024, 1, 0, e0);
                    term(0, 1024, 1, 1, e0);
                    exp_q.push_back('{0, 32'd2});
                end
                req[0] = 0; last[0] = 0;
            end
            begin
                int e1;
                for (int r = 0; r < 2; r++) begin
                    term(1, 1024, 3, 0, e1);
                    term(1, 1024, 3, 1, e1);
                    exp_q.push_back('{1, 32'd6});
                end
                req[1] = 0; last[1] = 0;
            end
        join
        wait_idle();

        // asynchronous reset in the middle of a 4-term burst
        gq.push_back(0);
        term(0, 1024, 7, 0, e);
        term(0, 1024, 7, 0, e);
        #3 reset = 1'b0;
        req[0] = 0;
        #1 chk("async_reset_outputs", 64'({gnt, res_valid, res_dout, busy}), 64'(0));
        chk("async_reset_acc", 64'(dut.r_acc), 64'(0));
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        repeat (10) @(negedge clock);
        gq.push_back(0);
        term(0, 1024, 9, 1, e);
        exp_q.push_back('{0, 32'd9});
        req[0] = 0; last[0] = 0;
        wait_idle();
        chk("grants_consumed", 64'(gq.size()), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fir_mac_arbiter.md
FIR_MAC_ARBITER -- requirements
Module: fir_mac_arbiter

Interface
REQ-001 Parameter DATA_SIZE, default 32: sample, coefficient, accumulator and result width.
REQ-002 Parameter NREQ, default 2: number of FIR requesters sharing one MAC.
REQ-003 Parameter DEQ_SHIFT, default 10: dequantize shift.
REQ-004 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port req, input, NREQ: per-requester term-valid request.
REQ-007 Port last, input, NREQ: marks the final term of a requester's burst; qualified by req.
REQ-008 Port a_in, input, NREQ x DATA_SIZE: signed sample operand per requester.
REQ-009 Port b_in, input, NREQ x DATA_SIZE: signed coefficient operand per requester.
REQ-010 Port gnt, output, NREQ: one-hot grant; term accepted in a cycle where req[i] and gnt[i] are both 1.
REQ-011 Port res_full, input, NREQ: per-requester output FIFO full.
REQ-012 Port res_valid, output, NREQ: one-hot write enable into the owner's output FIFO.
REQ-013 Port res_dout, output, DATA_SIZE: accumulated result; 0 when no res_valid bit is set.
REQ-014 Port busy, output, 1: 1 in every state except IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, BURST, DRAIN, and WRITE.
REQ-016 IDLE: if any req is 1, the block SHALL pick the owner by round-robin, starting at pointer rr_ptr and searching upward with wrap.
  - Same cycle: latch owner, clear accumulator, clear pipeline valid bits, go to BURST.
  - Otherwise: stay in IDLE.
REQ-017 gnt SHALL be 0 in IDLE, DRAIN, and WRITE; in BURST, gnt[owner] SHALL be 1 and all other bits 0.
REQ-018 Ownership SHALL be held until the owner's last term; no preemption, and req dropping mid-burst does not release the grant.
REQ-019 In BURST, a cycle with req[owner]=0 SHALL inject a pipeline bubble and leave the accumulator unchanged.
REQ-020 Stage 1 (registered): product = signed a_in[owner] x signed b_in[owner], 2*DATA_SIZE bits, with a valid bit.
REQ-021 Stage 2 (registered): if stage-1 valid, accumulator SHALL add dequant(product), truncated to DATA_SIZE, with wrap-around on overflow.
  - dequant(p) = p>>>DEQ_SHIFT for p>=0.
  - dequant(p) = -((-p)>>>DEQ_SHIFT) for p<0, i.e. truncate toward zero.
REQ-022 Acceptance of a term with last[owner]=1 SHALL move the FSM to DRAIN, which SHALL last exactly 2 cycles, then go to WRITE.
REQ-023 WRITE: if res_full[owner]=0, assert res_valid[owner]=1 with res_dout=accumulator for one cycle, set rr_ptr=(owner+1) mod NREQ, and go to IDLE.
  - If res_full[owner]=1: hold WRITE, keep the accumulator, assert no outputs.
REQ-024 Latency: last term accepted in cycle t SHALL give res_valid in cycle t+3 at the earliest; the next grant SHALL be no earlier than t+5.
REQ-025 A burst of one term (last=1 on the first accepted term) SHALL be legal and produce a single dequantized product.
REQ-026 Only the owner's res_full bit SHALL affect WRITE; non-owner requests SHALL be ignored until IDLE.
REQ-027 Simultaneous requests in IDLE SHALL resolve by rr_ptr, so each requester wins at most once before every other active requester has been served.

Reset
REQ-028 reset=0 SHALL immediately, without waiting for a clock edge:
  - force IDLE;
  - set rr_ptr=0;
  - clear owner, accumulator, product, and valid bits;
  - drive gnt=0, res_valid=0, res_dout=0, busy=0.
REQ-029 Reset asserted mid-burst SHALL discard the partial sum; no res_valid is produced for that burst after release.
REQ-030 The first request after reset release SHALL be arbitrated in the first rising edge with reset=1.

Verification
REQ-031 Bench SHALL cover: req0 only, 3 terms a=1024, b=5, last on the 3rd, res_full=0 -> gnt0 for 3 cycles, res_valid[0]=1 at t+3, res_dout=15, rr_ptr=1.
REQ-032 Bench SHALL cover: req0, single term a=-1, b=1023, last=1 -> res_dout=0 (not -1); then a=-2048, b=1 -> res_dout=-2 (0xFFFFFFFE).
REQ-033 Bench SHALL cover: req0 and req1 held high continuously after reset, 2-term bursts -> grants alternate 0,1,0,1; no requester is granted twice in a row.
REQ-034 Bench SHALL cover: res_full[1]=1 for 5 cycles during owner 1's WRITE -> FSM holds WRITE, gnt=0, res_valid=0; after release, exactly one res_valid[1] with the correct sum.
REQ-035 Bench SHALL cover: owner 0, req0 toggling 1,0,1,0,1 (last on the 3rd accepted term) with a=2048, b=1 -> gnt0 held throughout, res_dout=6, no grant to req1 mid-burst.
REQ-036 Bench SHALL cover: reset=0 asserted after the 2nd term of a 4-term burst -> outputs reset asynchronously; after release no stale res_valid, and the next burst result excludes the old terms.
